// File: rtl/stackcpu_result_log_pkg.sv
// Shared types and default sizes for the stack CPU result capture log.
package stackcpu_result_log_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned PC_WIDTH_DEF   = 8;
  localparam int unsigned LOG_DEPTH_DEF  = 8;
  localparam int unsigned DROP_WIDTH     = 8;

  typedef enum logic [1:0] {
    LOG_IDLE    = 2'd0,
    LOG_CAPTURE = 2'd1,
    LOG_FROZEN  = 2'd2
  } log_state_t;

endpackage

// File: rtl/stackcpu_result_log_result_fifo.sv
// Synchronous power-of-two FIFO with combinational head read; the caller
// guarantees no push when full without a pop and no pop when empty.
module result_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is reset too so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/stackcpu_result_log.sv
// Captures CPU results with pc/error into a FIFO, freezes on halt or error,
// and keeps sticky post-mortem status (halt pc, overflow, drop count).
module stackcpu_result_log
  import stackcpu_result_log_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned PC_WIDTH   = PC_WIDTH_DEF,
  parameter  int unsigned LOG_DEPTH  = LOG_DEPTH_DEF,
  localparam int unsigned CNT_WIDTH  = $clog2(LOG_DEPTH) + 1,
  localparam int unsigned ENT_WIDTH  = 1 + PC_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  valid_result,
  input  logic                  error,
  input  logic                  halt,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_result,
  output logic [PC_WIDTH-1:0]   rd_pc,
  output logic                  rd_err,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  overflow,
  output logic [DROP_WIDTH-1:0] drop_count,
  output logic [1:0]            state,
  output logic [PC_WIDTH-1:0]   halt_pc
);

  log_state_t           state_q;
  log_state_t           state_d;
  logic                 fifo_empty;
  logic                 wr_req;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [ENT_WIDTH-1:0] head;

  assign wr_req = valid_result && (state_q != LOG_FROZEN) && !clear;
  assign pop    = rd_valid && rd_ready && !clear;
  assign push   = wr_req && (!full || pop);
  assign drop   = wr_req && full && !pop;

  result_fifo #(
    .WIDTH (ENT_WIDTH),
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata ({error, pc, result}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  assign rd_valid                    = !fifo_empty;
  assign {rd_err, rd_pc, rd_result} = head;
  assign state                       = state_q;

  // Next-state: clear wins, then freeze, then first result starts capture.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = LOG_IDLE;
    end else begin
      case (state_q)
        LOG_IDLE: begin
          if (halt || error)     state_d = LOG_FROZEN;
          else if (valid_result) state_d = LOG_CAPTURE;
        end
        LOG_CAPTURE: if (halt || error) state_d = LOG_FROZEN;
        LOG_FROZEN:  state_d = LOG_FROZEN;
        default:     state_d = LOG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LOG_IDLE;
    else        state_q <= state_d;
  end

  // Sticky status; halt_pc is taken only on the cycle that freezes the log.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt_pc    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      halt_pc    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if ((state_q != LOG_FROZEN) && (halt || error)) halt_pc <= pc;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != {DROP_WIDTH{1'b1}}) drop_count <= drop_count + DROP_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_stackcpu_result_log.sv
// Bench for stackcpu_result_log: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_stackcpu_result_log;

  localparam int DW    = 16;
  localparam int PW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [DW-1:0] result;
  logic          valid_result;
  logic          error;
  logic          halt;
  logic [PW-1:0] pc;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_result;
  logic [PW-1:0] rd_pc;
  logic          rd_err;
  logic [2:0]    count;
  logic          full;
  logic          overflow;
  logic [7:0]    drop_count;
  logic [1:0]    state;
  logic [PW-1:0] halt_pc;

  always #5 clk = ~clk;

  stackcpu_result_log #(
    .DATA_WIDTH (DW),
    .PC_WIDTH   (PW),
    .LOG_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .result       (result),
    .valid_result (valid_result),
    .error        (error),
    .halt         (halt),
    .pc           (pc),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_result    (rd_result),
    .rd_pc        (rd_pc),
    .rd_err       (rd_err),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .state        (state),
    .halt_pc      (halt_pc)
  );

  typedef struct {
    logic          err;
    logic [PW-1:0] pc;
    logic [DW-1:0] res;
  } ent_t;

  // Reference model: 0 idle, 1 capture, 2 frozen
  ent_t          mq[$];
  int            m_state;
  logic          m_ov;
  int            m_drop;
  logic [PW-1:0] m_hpc;
  bit            chk_en;
  int            tests;
  int            fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0;
    m_ov    = 1'b0;
    m_drop  = 0;
    m_hpc   = '0;
  endtask

  task automatic model_step();
    bit popok;
    bit wr;
    bit dropped;
    if (clear) begin
      model_reset();
    end else begin
      popok   = (mq.size() > 0) && rd_ready;
      wr      = valid_result && (m_state != 2);
      dropped = wr && (mq.size() == DEPTH) && !popok;
      if (popok) void'(mq.pop_front());
      if (wr && !dropped) mq.push_back('{error, pc, result});
      if (dropped) begin
        m_ov = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if ((m_state != 2) && (halt || error)) begin
        m_state = 2;
        m_hpc   = pc;
      end else if ((m_state == 0) && valid_result) begin
        m_state = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("rd_result", 32'(rd_result), 32'(mq[0].res));
        check("rd_pc", 32'(rd_pc), 32'(mq[0].pc));
        check("rd_err", 32'(rd_err), 32'(mq[0].err));
      end
      check("count", 32'(count), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ov));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      check("state", 32'(state), 32'(m_state));
      check("halt_pc", 32'(halt_pc), 32'(m_hpc));
    end
  end

  // Drive one cycle of inputs, then advance model alongside the DUT edge.
  task automatic step(input logic vr, input logic [DW-1:0] res, input logic [PW-1:0] p,
                      input logic er, input logic ha, input logic cl, input logic rr);
    valid_result = vr;
    result       = res;
    pc           = p;
    error        = er;
    halt         = ha;
    clear        = cl;
    rd_ready     = rr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] res, input logic [PW-1:0] p);
    step(1'b1, res, p, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_clear(input logic ha);
    step(1'b0, '0, '0, 1'b0, ha, 1'b1, 1'b0);
  endtask

  logic [DW-1:0] exp_res [3];
  logic [PW-1:0] exp_pc  [3];

  initial begin
    tests = 0;
    fails = 0;
    chk_en = 1'b0;
    reset = 1'b0;
    clear = 1'b0;
    result = '0;
    valid_result = 1'b0;
    error = 1'b0;
    halt = 1'b0;
    pc = '0;
    rd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_result", 32'(rd_result), 32'd0);
    chk_en = 1'b1;

    // Three results then ordered drain
    wr(16'd5, 8'd1);
    wr(16'hFFFD, 8'd2);
    wr(16'd100, 8'd3);
    check("p1_count", 32'(count), 32'd3);
    check("p1_state", 32'(state), 32'd1);
    exp_res[0] = 16'd5;   exp_pc[0] = 8'd1;
    exp_res[1] = 16'hFFFD; exp_pc[1] = 8'd2;
    exp_res[2] = 16'd100; exp_pc[2] = 8'd3;
    for (int i = 0; i < 3; i++) begin
      check("p1_head_res", 32'(rd_result), 32'(exp_res[i]));
      check("p1_head_pc", 32'(rd_pc), 32'(exp_pc[i]));
      check("p1_head_err", 32'(rd_err), 32'd0);
      pop1();
    end
    check("p1_empty", 32'(rd_valid), 32'd0);

    // Overfill: six writes into four slots
    for (int i = 0; i < 6; i++) wr(16'(10 + i), 8'(20 + i));
    check("p2_count", 32'(count), 32'd4);
    check("p2_full", 32'(full), 32'd1);
    check("p2_overflow", 32'(overflow), 32'd1);
    check("p2_drop", 32'(drop_count), 32'd2);
    check("p2_head", 32'(rd_result), 32'd10);

    // Full with simultaneous write and pop
    step(1'b1, 16'd50, 8'd30, 1'b0, 1'b0, 1'b0, 1'b1);
    check("p3_count", 32'(count), 32'd4);
    check("p3_head", 32'(rd_result), 32'd11);
    check("p3_drop", 32'(drop_count), 32'd2);
    repeat (3) pop1();
    check("p3_tail", 32'(rd_result), 32'd50);
    pop1();

    // Result coincident with error is captured, then log freezes
    do_clear(1'b0);
    wr(16'd60, 8'd40);
    wr(16'd61, 8'd41);
    step(1'b1, 16'd7, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    check("p4_count", 32'(count), 32'd3);
    check("p4_state", 32'(state), 32'd2);
    check("p4_halt_pc", 32'(halt_pc), 32'd9);
    wr(16'd99, 8'd50);
    wr(16'd98, 8'd51);
    check("p4_ignored", 32'(count), 32'd3);
    pop1();
    check("p4_drain_count", 32'(count), 32'd2);
    pop1();
    check("p4_err_res", 32'(rd_result), 32'd7);
    check("p4_err_pc", 32'(rd_pc), 32'd9);
    check("p4_err_flag", 32'(rd_err), 32'd1);
    wr(16'd97, 8'd52);
    do_clear(1'b0);
    check("p4_clr_count", 32'(count), 32'd0);
    check("p4_clr_ovf", 32'(overflow), 32'd0);
    check("p4_clr_state", 32'(state), 32'd0);
    check("p4_clr_hpc", 32'(halt_pc), 32'd0);

    // Clear while halt held: idle for one cycle, then frozen again
    do_clear(1'b1);
    check("p4_clr_halt_state", 32'(state), 32'd0);
    step(1'b0, '0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    check("p4_refreeze", 32'(state), 32'd2);
    check("p4_refreeze_pc", 32'(halt_pc), 32'h33);
    do_clear(1'b0);

    // Async reset mid-stream with nonzero status
    for (int i = 0; i < 5; i++) wr(16'(200 + i), 8'(60 + i));
    step(1'b0, '0, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
    check("p5_pre_ovf", 32'(overflow), 32'd1);
    #3;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_result", 32'(rd_result), 32'd0);
    check("rst_rd_pc", 32'(rd_pc), 32'd0);
    check("rst_rd_err", 32'(rd_err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_halt_pc", 32'(halt_pc), 32'd0);
    model_reset();
    valid_result = 1'b0;
    error = 1'b0;
    rd_ready = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    chk_en = 1'b1;

    // Drop counter saturation
    for (int i = 0; i < DEPTH + 300; i++) wr(16'(i), 8'(i));
    check("p6_drop_sat", 32'(drop_count), 32'd255);
    check("p6_ovf", 32'(overflow), 32'd1);
    check("p6_count", 32'(count), 32'd4);
    check("p6_head", 32'(rd_result), 32'd0);

    // Randomized traffic against the model
    do_clear(1'b0);
    for (int i = 0; i < 1200; i++) begin
      logic rr;
      if (((i / 100) % 2) == 1) rr = ($urandom_range(0, 3) == 0);
      else                      rr = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
           $urandom_range(0, 60) == 0, $urandom_range(0, 60) == 0,
           $urandom_range(0, 40) == 0, rr);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
